// File: rtl/car_counter.sv
// car_counter: parking-lot occupancy counter.
//
// It watches the entry-lane and exit-lane beam pairs and decodes complete
// car passages. It keeps the number of parked cars, drives the entry gate
// enable, and reports rejected entries and exit underflow.
//
// Ports:
//   clk            system clock, rising edge
//   rst            asynchronous reset, active low
//   in_a, in_b     entry lane outer / inner beam (1 = blocked), async to clk
//   out_a, out_b   exit lane inner / outer beam (1 = blocked), async to clk
//   clr_err        synchronous clear of err_underflow
//   count          cars parked, 0..CAPACITY
//   gate_open      entry barrier enable (count < CAPACITY)
//   car_in         one-cycle pulse per accepted entry
//   car_out        one-cycle pulse per accepted exit
//   reject         one-cycle pulse when an entry completes at full
//   err_underflow  sticky, set when an exit completes at count == 0

// Per-sensor conditioning: a 2-flop synchronizer followed by a debouncer.
// The debounced value flips after DEB_CYCLES consecutive disagreeing cycles.
module car_counter_cond #(
    parameter int DEB_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic deb
);
    localparam logic [3:0] DEB_LAST = 4'(DEB_CYCLES - 1);

    logic       s1, s2;
    logic [3:0] cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1  <= 1'b0;
            s2  <= 1'b0;
            deb <= 1'b0;
            cnt <= '0;
        end else begin
            s1 <= raw;
            s2 <= s1;
            if (s2 != deb) begin
                // The last disagreeing cycle flips the value at this edge.
                if (cnt == DEB_LAST) begin
                    deb <= s2;
                    cnt <= '0;
                end else begin
                    cnt <= cnt + 4'd1;
                end
            end else begin
                cnt <= '0;
            end
        end
    end
endmodule

// Per-lane passage decoder. Here a is the first beam met in the travel
// direction. evt is high during the cycle in which the FSM leaves S_B on a
// clear (0,0). The top level registers the pulse and the new count on that
// same edge.
module car_counter_lane (
    input  logic clk,
    input  logic rst,
    input  logic a,
    input  logic b,
    output logic evt
);
    typedef enum logic [1:0] {IDLE, S_A, S_AB, S_B} state_t;
    state_t state;

    assign evt = (state == S_B) && !a && !b;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            unique case (state)
                IDLE: if (a && !b) state <= S_A;
                S_A: begin
                    if (a && b)        state <= S_AB;
                    else if (!a)       state <= IDLE;  // backed out or invalid
                end
                S_AB: begin
                    if (!a && b)       state <= S_B;
                    else if (a && !b)  state <= S_A;
                    else if (!a && !b) state <= IDLE;
                end
                S_B: begin
                    if (a && b)        state <= S_AB;
                    else if (!b)       state <= IDLE;  // (0,0) is the passage
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

module car_counter #(
    parameter int CAPACITY   = 12,
    parameter int DEB_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_a,
    input  logic       in_b,
    input  logic       out_a,
    input  logic       out_b,
    input  logic       clr_err,
    output logic [3:0] count,
    output logic       gate_open,
    output logic       car_in,
    output logic       car_out,
    output logic       reject,
    output logic       err_underflow
);
    localparam logic [3:0] CAP = 4'(CAPACITY);

    logic [3:0] raw, deb;
    logic [1:0] evt;      // [0] entry lane, [1] exit lane

    assign raw = {out_b, out_a, in_b, in_a};

    for (genvar i = 0; i < 4; i++) begin : g_cond
        car_counter_cond #(.DEB_CYCLES(DEB_CYCLES)) u_cond (
            .clk (clk),
            .rst (rst),
            .raw (raw[i]),
            .deb (deb[i])
        );
    end

    for (genvar g = 0; g < 2; g++) begin : g_lane
        car_counter_lane u_lane (
            .clk (clk),
            .rst (rst),
            .a   (deb[2*g]),
            .b   (deb[2*g+1]),
            .evt (evt[g])
        );
    end

    assign gate_open = (count < CAP);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count         <= '0;
            car_in        <= 1'b0;
            car_out       <= 1'b0;
            reject        <= 1'b0;
            err_underflow <= 1'b0;
        end else begin
            car_in  <= 1'b0;
            car_out <= 1'b0;
            reject  <= 1'b0;
            // A clear can be overridden below by a new underflow in the same cycle.
            if (clr_err) err_underflow <= 1'b0;
            unique case (evt)
                2'b01: begin
                    if (count < CAP) begin
                        count  <= count + 4'd1;
                        car_in <= 1'b1;
                    end else begin
                        reject <= 1'b1;
                    end
                end
                2'b10: begin
                    if (count != 4'd0) begin
                        count   <= count - 4'd1;
                        car_out <= 1'b1;
                    end else begin
                        err_underflow <= 1'b1;
                    end
                end
                2'b11: begin
                    if (count >= CAP) begin
                        // At full, the exit frees a space but the entry has
                        // already been refused.
                        count   <= count - 4'd1;
                        car_out <= 1'b1;
                        reject  <= 1'b1;
                    end else if (count == 4'd0) begin
                        count         <= count + 4'd1;
                        car_in        <= 1'b1;
                        err_underflow <= 1'b1;
                    end else begin
                        car_in  <= 1'b1;
                        car_out <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_car_counter.sv
// Scoreboard bench for car_counter. The stimulus pushes the expected output
// record for each passage. A monitor pops a record and compares it whenever
// the DUT pulses an output or raises err_underflow.
module tb_car_counter;
    logic       clk = 1'b0;
    logic       rst;
    logic       in_a, in_b, out_a, out_b, clr_err;
    logic [3:0] count;
    logic       gate_open, car_in, car_out, reject, err_underflow;

    typedef struct packed {
        logic       ci;
        logic       co;
        logic       rj;
        logic       er;
        logic [3:0] cnt;
    } rec_t;

    rec_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    logic err_prev = 1'b0;

    localparam logic [7:0] CLEAN = 8'b10_11_01_00;
    localparam logic [7:0] ABORT = 8'b10_11_10_00;

    car_counter #(.CAPACITY(12), .DEB_CYCLES(4)) dut (
        .clk           (clk),
        .rst           (rst),
        .in_a          (in_a),
        .in_b          (in_b),
        .out_a         (out_a),
        .out_b         (out_b),
        .clr_err       (clr_err),
        .count         (count),
        .gate_open     (gate_open),
        .car_in        (car_in),
        .car_out       (car_out),
        .reject        (reject),
        .err_underflow (err_underflow)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    // Monitor: every output event must match the head of the queue.
    always @(negedge clk) begin
        rec_t got, e;
        if (rst && (car_in || car_out || reject || (err_underflow && !err_prev))) begin
            got = '{ci: car_in, co: car_out, rj: reject, er: err_underflow, cnt: count};
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_event: got in=%0b out=%0b rej=%0b err=%0b cnt=%0d, required no event",
                         got.ci, got.co, got.rj, got.er, got.cnt);
            end else begin
                e = exp_q.pop_front();
                if (got != e) begin
                    errors++;
                    $display("FAIL event: got in=%0b out=%0b rej=%0b err=%0b cnt=%0d, required in=%0b out=%0b rej=%0b err=%0b cnt=%0d",
                             got.ci, got.co, got.rj, got.er, got.cnt, e.ci, e.co, e.rj, e.er, e.cnt);
                end
            end
        end
        err_prev = err_underflow;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int got, input int req);
        checks++;
        if (got != req) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d", name, got, req);
        end
    endtask

    // lanes bit0 = entry lane, bit1 = exit lane; each (a,b) step held 10 cycles.
    task automatic pass(input logic [1:0] lanes, input logic [7:0] seq);
        logic [1:0] ab;
        for (int i = 3; i >= 0; i--) begin
            ab = seq[2*i+1 -: 2];
            if (lanes[0]) {in_a, in_b}   = ab;
            if (lanes[1]) {out_a, out_b} = ab;
            tick(10);
        end
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 40 && exp_q.size() != 0; i++) tick(1);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s: %0d expected events still pending, required 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic push(input logic ci, co, rj, er, input int cnt);
        exp_q.push_back('{ci: ci, co: co, rj: rj, er: er, cnt: 4'(cnt)});
    endtask

    initial begin
        rst = 1'b0;
        {in_a, in_b, out_a, out_b, clr_err} = '0;
        tick(3);
        chk("reset_count", count, 0);
        chk("reset_gate", gate_open, 1);
        chk("reset_pulses", {car_in, car_out, reject}, 0);
        chk("reset_err", err_underflow, 0);
        rst = 1'b1;
        tick(2);

        // Seven entries, then an asynchronous reset with a car in the beams.
        for (int i = 1; i <= 7; i++) begin
            push(1, 0, 0, 0, i);
            pass(2'b01, CLEAN);
            drain("entry_drain");
        end
        chk("count_before_reset", count, 7);
        {in_a, in_b} = 2'b10; tick(10);
        {in_a, in_b} = 2'b11; tick(10);
        #2 rst = 1'b0;
        #1;
        chk("async_reset_count", count, 0);
        chk("async_reset_gate", gate_open, 1);
        chk("async_reset_pulses", {car_in, car_out, reject, err_underflow}, 0);
        tick(2);
        rst = 1'b1;
        {in_a, in_b} = 2'b01; tick(10);
        {in_a, in_b} = 2'b00; tick(12);
        chk("reset_mid_passage_count", count, 0);

        // Fill to capacity.
        for (int i = 1; i <= 12; i++) begin
            push(1, 0, 0, 0, i);
            pass(2'b01, CLEAN);
            drain("fill_drain");
        end
        chk("full_count", count, 12);
        chk("full_gate", gate_open, 0);

        push(0, 0, 1, 0, 12);
        pass(2'b01, CLEAN);
        drain("reject_drain");
        chk("reject_count", count, 12);

        pass(2'b01, ABORT);
        tick(5);
        chk("abort_count", count, 12);

        // Simultaneous entry and exit at full.
        push(0, 1, 1, 0, 11);
        pass(2'b11, CLEAN);
        drain("simul_full_drain");
        chk("simul_full_gate", gate_open, 1);

        for (int c = 10; c >= 5; c--) begin
            push(0, 1, 0, 0, c);
            pass(2'b10, CLEAN);
            drain("exit_drain");
        end
        chk("count_5", count, 5);

        push(1, 1, 0, 0, 5);
        pass(2'b11, CLEAN);
        drain("simul_mid_drain");
        chk("simul_mid_count", count, 5);

        for (int c = 4; c >= 0; c--) begin
            push(0, 1, 0, 0, c);
            pass(2'b10, CLEAN);
            drain("exit_down_drain");
        end
        chk("empty_count", count, 0);

        // Underflow is sticky until clr_err.
        push(0, 0, 0, 1, 0);
        pass(2'b10, CLEAN);
        drain("underflow_drain");
        tick(20);
        chk("underflow_sticky", err_underflow, 1);
        chk("underflow_count", count, 0);
        clr_err = 1'b1; tick(1); clr_err = 1'b0;
        chk("underflow_cleared", err_underflow, 0);

        // Simultaneous events at empty: the entry counts and underflow is set.
        push(1, 0, 0, 1, 1);
        pass(2'b11, CLEAN);
        drain("simul_empty_drain");
        chk("simul_empty_err", err_underflow, 1);
        clr_err = 1'b1; tick(1); clr_err = 1'b0;
        chk("simul_empty_clear", err_underflow, 0);

        // Debounce: short glitches are filtered; a DEB_CYCLES glitch gives
        // an aborted passage.
        for (int g = 0; g < 3; g++) begin
            in_a = 1'b1; tick(3);
            in_a = 1'b0; tick(10);
        end
        chk("glitch3_count", count, 1);
        in_a = 1'b1; tick(4);
        in_a = 1'b0; tick(20);
        chk("glitch4_count", count, 1);
        chk("final_gate", gate_open, 1);
        chk("final_queue_empty", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/car_counter.md
# car_counter

Occupancy counter for the parking system: watches the entry-lane and exit-lane beam-sensor pairs and decodes complete car passages. It maintains the number of parked cars and drives the `count` input of the floor-allocation FSM. It also drives the entry gate enable and reports rejected entries and exit underflow. It sits directly upstream of the floor/full FSM.

## Interface
- `CAPACITY`, default 12: maximum cars; `count` saturates here.
- `DEB_CYCLES`, default 4: consecutive stable cycles needed before a debounced sensor changes; legal range 1..15.
- `clk`  input  1: system clock, all logic on rising edge.
- `rst`  input  1: reset, asynchronous, active-low (asserted when 0).
- `in_a`  input  1: entry lane outer beam, 1 = blocked; asynchronous to clk.
- `in_b`  input  1: entry lane inner beam, 1 = blocked; asynchronous.
- `out_a`  input  1: exit lane inner beam, 1 = blocked; asynchronous.
- `out_b`  input  1: exit lane outer beam, 1 = blocked; asynchronous.
- `clr_err`  input  1: synchronous clear of `err_underflow`.
- `count`  output  4: cars parked, 0..CAPACITY; feeds the floor FSM.
- `gate_open`  output  1: entry barrier enable, `count < CAPACITY`.
- `car_in`  output  1: one-cycle pulse per accepted entry.
- `car_out`  output  1: one-cycle pulse per accepted exit.
- `reject`  output  1: one-cycle pulse when an entry completes at full.
- `err_underflow`  output  1: sticky; set when an exit completes with `count == 0`.

## Operation
- **Input conditioning:**
  - Each sensor passes through a 2-flop synchronizer, then a debouncer.
  - The debouncer holds a registered value and a small counter.
  - When the synchronized input differs from the debounced value for DEB_CYCLES consecutive cycles, the debounced value flips and the counter clears.
  - Any cycle where the input matches the debounced value clears the counter.
- **Lane decoders:** two identical 4-state FSMs, one per lane. Each operates on its debounced (a,b) pair, where a is the first beam met in the travel direction.
  - IDLE: (1,0) -> S_A; all other inputs stay in IDLE.
  - S_A: (1,1) -> S_AB; (0,0) -> IDLE (car backed out, no event); (0,1) -> IDLE (invalid, no event); (1,0) stays.
  - S_AB: (0,1) -> S_B; (1,0) -> S_A; (0,0) -> IDLE (no event); (1,1) stays.
  - S_B: (0,0) -> IDLE and raise a passage event; (1,1) -> S_AB; (1,0) -> IDLE (no event); (0,1) stays.
- **Counter update, per cycle, from the entry event E and exit event X:**
  - E only, count < CAPACITY: count+1 and car_in=1.
  - E only, count == CAPACITY: count held and reject=1.
  - X only, count > 0: count−1 and car_out=1.
  - X only, count == 0: count held and err_underflow set.
  - E and X together, 0 < count < CAPACITY: count held, car_in=1, car_out=1.
  - E and X together, count == CAPACITY: exit applied (count−1, car_out=1); entry rejected (reject=1).
  - E and X together, count == 0: entry applied (count+1, car_in=1); underflow set.
- count never leaves 0..CAPACITY; arithmetic is 4-bit unsigned.
- err_underflow clears only on clr_err=1 or reset. A simultaneous set and clr_err resolves to set.
- gate_open is combinational from the count register.

## Timing
- Reset values (async assert, synchronous-safe deassert):
  - count=0; gate_open=1; car_in, car_out, reject, err_underflow all 0.
  - Debounced values 0; both FSMs IDLE; synchronizers 0.
- Raw-to-debounced latency: 2 sync cycles + DEB_CYCLES cycles.
- Passage event: the FSM's S_B -> IDLE transition edge also registers the pulse outputs and the new count. Pulse and count change are visible in the same cycle, one edge after the debounced (0,0) is seen.
- Pulses last exactly one cycle. Back-to-back events produce separate pulses.
- A raw glitch shorter than DEB_CYCLES cycles (after sync) has no effect.
- Reset mid-passage: the FSM returns to IDLE. A car still in the beams when reset deasserts is not counted until the FSM sees a fresh (1,0).

## Test plan
- **Reset:** drive rst=0 mid-operation with count=7 -> all outputs go to reset values asynchronously; after release, count=0 and gate_open=1.
- **Clean entry:** in lane (a,b) sequence 10, 11, 01, 00, each held 10 cycles, with DEB_CYCLES=4 -> exactly one car_in pulse and count 0->1. Repeat 12 times -> count=12, gate_open=0.
- **Full plus aborts:**
  - At count=12, one more full entry -> reject pulse, count stays 12.
  - Sequence 10, 11, 10, 00 -> no event, count unchanged.
- **Exit and underflow:**
  - At count=3, a clean exit -> car_out pulse, count=2.
  - At count=0, a clean exit -> err_underflow=1, count=0. It stays set until clr_err=1 for one cycle.
- **Simultaneous events:**
  - Entry and exit completing the same cycle at count=5 -> count=5, with car_in and car_out both pulsed.
  - Same at count=12 -> count=11, car_out=1, reject=1.
- **Debounce:** 3-cycle glitches on in_a while idle -> no state change. A glitch of DEB_CYCLES cycles -> FSM reaches S_A, with no count change when the beam clears.
